// File: rtl/fu_complete_buffer_pkg.sv
// Shared FU->complete interface types and widths, common to this buffer and the complete stage.
`ifndef PR
`define PR 6
`endif
`ifndef ROB
`define ROB 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

package fu_complete_buffer_pkg;
  localparam int NUM_FU  = 8;
  localparam int NUM_CDB = 3;
  localparam int HOLD_W  = 8;

  typedef struct packed {
    logic [`PR-1:0]   dest_pr;
    logic [`XLEN-1:0] dest_value;
    logic [`ROB-1:0]  rob_entry;
    logic             if_take_branch;
    logic [`XLEN-1:0] target_pc;
  } FU_COMPLETE_PACKET;

  typedef logic [NUM_FU-1:0] FU_STATE_PACKET;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/fu_slot_reg.sv
// One FU result holding register: capture when ready, release on accept, hold on stall, drop on squash.
// Hold-run counter exists only when FU_CBUF_PERF_EN is defined.
module fu_slot_reg
  import fu_complete_buffer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              squash_i,
  input  logic              in_valid_i,
  input  FU_COMPLETE_PACKET in_pkt_i,
  input  logic              stall_i,
  output logic              valid_o,
  output FU_COMPLETE_PACKET pkt_o,
  output logic              ready_o
`ifdef FU_CBUF_PERF_EN
  ,
  output logic [HOLD_W-1:0] hold_next_o
`endif
);
  slot_state_e       state_q, state_d;
  FU_COMPLETE_PACKET pkt_q, pkt_d;
  logic              accept, capture;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    ready_o = (state_q == SLOT_EMPTY) || !stall_i;
    accept  = (state_q == SLOT_FULL) && !stall_i;
    capture = in_valid_i && ready_o;
    if (squash_i) begin
      state_d = SLOT_EMPTY;
    end else if (capture) begin
      state_d = SLOT_FULL;
      pkt_d   = in_pkt_i;
    end else if (accept) begin
      state_d = SLOT_EMPTY;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign pkt_o   = pkt_q;

`ifdef FU_CBUF_PERF_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  always_comb begin
    hold_d = hold_q;
    if (squash_i || accept)
      hold_d = '0;
    else if (valid_o && stall_i && (hold_q != {HOLD_W{1'b1}}))
      hold_d = hold_q + HOLD_W'(1);
  end

  assign hold_next_o = hold_d;
`endif

  // A result offered while not ready must be dropped: the held packet stays put.
  a_ignore_when_not_ready : assert property (@(posedge clock) disable iff (reset)
    (in_valid_i && !ready_o && !squash_i) |=> (valid_o && pkt_q == $past(pkt_q)));
endmodule

// File: rtl/fu_complete_buffer.sv
// FU->complete transmitter: per-FU holding slots plus highest-index-first packing into NUM_CDB slots.
// Optional counters stall_cycles/max_hold are enabled by FU_CBUF_PERF_EN.
module fu_complete_buffer
  import fu_complete_buffer_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  FU_STATE_PACKET                   fu_out_valid,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0]   fu_out,
  output FU_STATE_PACKET                   fu_ready,
  output FU_STATE_PACKET                   fu_finish,
  output FU_COMPLETE_PACKET [NUM_CDB-1:0]  fu_c_in,
  input  FU_STATE_PACKET                   fu_c_stall
`ifdef FU_CBUF_PERF_EN
  ,
  output logic [31:0]                      stall_cycles,
  output logic [HOLD_W-1:0]                max_hold
`endif
);
  localparam int CW = $clog2(NUM_CDB + 1);

  FU_COMPLETE_PACKET slot_pkt [NUM_FU];
`ifdef FU_CBUF_PERF_EN
  logic [HOLD_W-1:0] hold_next [NUM_FU];
`endif

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
    fu_slot_reg u_slot (
      .clock       (clock),
      .reset       (reset),
      .squash_i    (squash),
      .in_valid_i  (fu_out_valid[gi]),
      .in_pkt_i    (fu_out[gi]),
      .stall_i     (fu_c_stall[gi]),
      .valid_o     (fu_finish[gi]),
      .pkt_o       (slot_pkt[gi]),
      .ready_o     (fu_ready[gi])
`ifdef FU_CBUF_PERF_EN
      ,
      .hold_next_o (hold_next[gi])
`endif
    );
  end

  // Top slot gets the highest-index valid FU, matching the complete stage's own selection order.
  logic [CW-1:0] used;
  always_comb begin
    fu_c_in = '0;
    used    = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (fu_finish[i] && (used < CW'(NUM_CDB))) begin
        fu_c_in[CW'(NUM_CDB - 1) - used] = slot_pkt[i];
        used = used + CW'(1);
      end
    end
  end

`ifdef FU_CBUF_PERF_EN
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic [HOLD_W-1:0] max_hold_q, max_hold_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      max_hold_q     <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      max_hold_q     <= max_hold_d;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, |(fu_c_stall & fu_finish)};
    max_hold_d     = max_hold_q;
    for (int i = 0; i < NUM_FU; i++)
      if (hold_next[i] > max_hold_d) max_hold_d = hold_next[i];
  end

  assign stall_cycles = stall_cycles_q;
  assign max_hold     = max_hold_q;
`endif
endmodule

// File: tb/tb_fu_complete_buffer.sv
// Randomized plus directed bench for fu_complete_buffer against a queue-based behavioural model.
module tb_fu_complete_buffer;
  import fu_complete_buffer_pkg::*;

  logic                            clock = 1'b0;
  logic                            reset = 1'b1;
  logic                            squash = 1'b0;
  FU_STATE_PACKET                  fu_out_valid = '0;
  FU_COMPLETE_PACKET [NUM_FU-1:0]  fu_out = '0;
  FU_STATE_PACKET                  fu_ready;
  FU_STATE_PACKET                  fu_finish;
  FU_COMPLETE_PACKET [NUM_CDB-1:0] fu_c_in;
  FU_STATE_PACKET                  fu_c_stall = '0;

  fu_complete_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .fu_out_valid (fu_out_valid),
    .fu_out       (fu_out),
    .fu_ready     (fu_ready),
    .fu_finish    (fu_finish),
    .fu_c_in      (fu_c_in),
    .fu_c_stall   (fu_c_stall)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  FU_STATE_PACKET    m_valid = '0;
  FU_COMPLETE_PACKET m_pkt [NUM_FU];
  FU_COMPLETE_PACKET exp_a, exp_b;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic FU_COMPLETE_PACKET mk(input int pr, input int val, input int rob,
                                           input bit br, input int pc);
    FU_COMPLETE_PACKET p;
    p.dest_pr        = pr[`PR-1:0];
    p.dest_value     = val;
    p.rob_entry      = rob[`ROB-1:0];
    p.if_take_branch = br;
    p.target_pc      = pc;
    return p;
  endfunction

  // Valid FUs in complete-stage priority order (highest index first).
  function automatic void priority_list(output int order[$]);
    order = {};
    for (int i = NUM_FU - 1; i >= 0; i--) if (m_valid[i]) order.push_back(i);
  endfunction

  task automatic compare_all();
    FU_STATE_PACKET exp_ready;
    int order[$];
    for (int i = 0; i < NUM_FU; i++) exp_ready[i] = !m_valid[i] || !fu_c_stall[i];
    priority_list(order);
    check("fu_finish", fu_finish, m_valid);
    check("fu_ready", fu_ready, exp_ready);
    for (int k = 0; k < NUM_CDB; k++) begin
      FU_COMPLETE_PACKET e;
      e = (k < order.size()) ? m_pkt[order[k]] : '0;
      check($sformatf("fu_c_in[%0d]", NUM_CDB - 1 - k), fu_c_in[NUM_CDB - 1 - k], e);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NUM_FU; i++) begin
      if (squash) begin
        m_valid[i] = 1'b0;
      end else if (fu_out_valid[i] && (!m_valid[i] || !fu_c_stall[i])) begin
        m_valid[i] = 1'b1;
        m_pkt[i]   = fu_out[i];
      end else if (m_valid[i] && !fu_c_stall[i]) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  // Called at a negedge: apply inputs, check, advance one clock, return at the next negedge.
  task automatic cycle(input FU_STATE_PACKET v, input FU_STATE_PACKET st, input logic sq);
    fu_out_valid = v;
    fu_c_stall   = st;
    squash       = sq;
    #1;
    compare_all();
    $display("cycle t=%0t valid=%h stall=%h squash=%0b finish=%h ready=%h",
             $time, v, st, sq, fu_finish, fu_ready);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < NUM_FU; i++) m_pkt[i] = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    cycle('0, '0, 1'b0);

    // Single FU3 result
    fu_out[3] = mk(5, 'hAB, 3, 1'b0, 0);
    cycle(8'h08, '0, 1'b0);
    check("fu3_finish", fu_finish, 8'h08);
    check("fu3_slot2_pr", fu_c_in[2].dest_pr, 5);
    check("fu3_slot10", fu_c_in[1:0], '0);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);

    // Four FUs at once; lowest one is stalled and moves to slot 2
    fu_out[7] = mk(7, 'h77, 7, 1'b0, 0);
    fu_out[5] = mk(9, 'h55, 5, 1'b0, 0);
    fu_out[2] = mk(11, 'h22, 2, 1'b0, 0);
    exp_a     = mk(13, 'h11, 1, 1'b0, 0);
    fu_out[0] = exp_a;
    cycle(8'hA5, '0, 1'b0);
    cycle('0, 8'h01, 1'b0);
    check("fu0_held_finish", fu_finish, 8'h01);
    check("fu0_slot2", fu_c_in[2], exp_a);
    cycle('0, '0, 1'b0);

    // FU4 held for three cycles while it keeps offering, then back-to-back replace
    exp_a     = mk(20, 'hA0A0, 4, 1'b0, 0);
    exp_b     = mk(21, 'hB0B0, 6, 1'b0, 0);
    fu_out[4] = exp_a;
    cycle(8'h10, '0, 1'b0);
    fu_out[4] = exp_b;
    repeat (3) cycle(8'h10, 8'h10, 1'b0);
    check("fu4_held_pkt", fu_c_in[2], exp_a);
    cycle(8'h10, '0, 1'b0);
    check("fu4_b2b_finish", fu_finish, 8'h10);
    check("fu4_b2b_pkt", fu_c_in[2], exp_b);
    cycle('0, '0, 1'b0);

    // Branch result on FU6
    fu_out[6] = mk(30, 'h1, 13, 1'b1, 'h1000);
    cycle(8'h40, '0, 1'b0);
    check("fu6_target_pc", fu_c_in[2].target_pc, 32'h1000);
    check("fu6_rob", fu_c_in[2].rob_entry, 13);
    check("fu6_taken", fu_c_in[2].if_take_branch, 1'b1);
    cycle('0, '0, 1'b0);

    // Squash while FUs 1,6 are held and FU2 captures
    fu_out[1] = mk(40, 'h41, 1, 1'b0, 0);
    fu_out[2] = mk(42, 'h42, 2, 1'b0, 0);
    cycle(8'h42, '0, 1'b0);
    cycle(8'h04, 8'h42, 1'b1);
    check("squash_finish", fu_finish, '0);
    check("squash_c_in", fu_c_in, '0);
    cycle('0, '0, 1'b0);

    // Asynchronous reset between edges with FUs held
    cycle(8'h42, '0, 1'b0);
    fu_out_valid = '0;
    fu_c_stall   = 8'hFF;
    #2 reset = 1'b1;
    #1;
    check("areset_finish", fu_finish, '0);
    check("areset_c_in", fu_c_in, '0);
    check("areset_ready", fu_ready, 8'hFF);
    $display("async reset t=%0t finish=%h ready=%h", $time, fu_finish, fu_ready);
    #1 reset = 1'b0;
    m_valid = '0;
    for (int i = 0; i < NUM_FU; i++) m_pkt[i] = '0;
    @(negedge clock);
    cycle('0, '0, 1'b0);

    // Randomized traffic, including results offered while not ready
    for (int n = 0; n < 400; n++) begin
      int order[$];
      FU_STATE_PACKET st;
      for (int i = 0; i < NUM_FU; i++)
        fu_out[i] = mk($urandom_range(0, 63), $urandom, $urandom_range(0, 31),
                       1'($urandom), $urandom);
      priority_list(order);
      st = 8'($urandom) & 8'($urandom) & m_valid;
      for (int k = NUM_CDB; k < order.size(); k++) st[order[k]] = 1'b1;
      cycle(8'($urandom), st, ($urandom_range(0, 24) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fu_complete_buffer.md
Name: fu_complete_buffer

Overview:
- Sits between the 8 functional units and the complete stage; it is the transmitter side of the FU→complete interface.
- Each FU gets one result holding register. The block drives `fu_finish` and a packed `fu_c_in[2:0]` toward the complete stage.
- It consumes `fu_c_stall`: stalled results are held and re-offered next cycle, and backpressure goes to the FU.
- All results are flushed on squash.

Parameters:
- NUM_FU, 8, number of FU ports; fixed width of FU_STATE_PACKET.
- NUM_CDB, 3, complete slots per cycle.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- squash  in  1  mispredict flush; clears all holding registers
- fu_out_valid  in  NUM_FU  FU i has a finished result this cycle
- fu_out  in  NUM_FU x FU_COMPLETE_PACKET  per-FU result (dest_pr, dest_value, rob_entry, if_take_branch, target_pc)
- fu_ready  out  NUM_FU  FU i may present a new result this cycle
- fu_finish  out  FU_STATE_PACKET  holding-register valid bits, driven straight from flops
- fu_c_in  out  NUM_CDB x FU_COMPLETE_PACKET  packed results offered to the complete stage
- fu_c_stall  in  FU_STATE_PACKET  from complete stage, same cycle; bit i=1 means FU i was not accepted

Behaviour:
- Per-FU state is one bit, EMPTY/FULL, plus a FU_COMPLETE_PACKET register.
- Reset (async): all valid=0, all packet registers=0. Hence `fu_finish`=0, `fu_c_in`=all zero, `fu_ready`=all 1.
- accept[i] = valid[i] & ~fu_c_stall[i].
- fu_ready[i] = ~valid[i] | ~fu_c_stall[i] (combinational). Write "fu_c_stall" in full; no abbreviation.
- Capture rule: fu_out_valid[i] & fu_ready[i] → register loads fu_out[i] and valid[i]=1 next cycle. Latency is exactly 1 cycle from FU valid to `fu_finish`.
- Transitions:
  - EMPTY→FULL on capture.
  - FULL→FULL on accept and new capture in the same cycle (back-to-back; no bubble).
  - FULL→EMPTY on accept with no capture.
  - FULL held on stall; register unchanged.
- fu_out_valid[i] while fu_ready[i]=0 is a protocol violation. It is ignored; covered by an assertion.
- Packing is combinational from the registered valid bits and uses fixed priority, highest FU index first. This equals the complete stage's selection order.
  - 1st-priority valid FU → fu_c_in[2].
  - 2nd → fu_c_in[1].
  - 3rd → fu_c_in[0].
  - Unused slots are driven all-zero: dest_pr=0 means no writeback.
- The 4th and later valid FUs are not packed. The complete stage stalls them and they retry next cycle.
- squash: all valid cleared next edge, and any same-cycle capture is suppressed. Squash takes priority over capture and hold.
- Reset asserted mid-operation clears state immediately, with no edge needed.
- With valid=0, contents are don't-care internally but must not leak: fu_c_in is gated by the valid bits.

Optional Feature:
- Macro: FU_CBUF_PERF_EN.
- When defined:
  - Output `stall_cycles` (32 bits): count of cycles in which any bit of fu_c_stall&valid is set.
  - Output `max_hold` (8 bits): longest consecutive stall run observed for any single FU. It uses per-FU 8-bit saturating hold counters that reset to 0 on accept or squash.
  - All counters reset to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package / sys_defs:
  - FU_COMPLETE_PACKET and FU_STATE_PACKET typedefs (already shared with the complete stage).
  - `PR, `ROB, `XLEN width macros.
  - NUM_CDB constant.
- One natural sub-module: fu_slot_reg. It holds the single-FU valid/packet register with capture, accept, squash and ready logic, and is instantiated NUM_FU times. Packing stays in the top.

Test Plan:
- FU3 valid with dest_pr=5, value=0xAB; no stall → fu_finish=8'h08 next cycle; fu_c_in[2].dest_pr=5; fu_c_in[1:0]=0; fu_ready[3]=1 throughout.
- FUs 7,5,2,0 valid together → slots [2],[1],[0] = FU7, FU5, FU2. With fu_c_stall=8'h01, FU0 is held. The next cycle shows fu_finish=8'h01 and FU0 in slot 2.
- FU4 held with fu_c_stall[4]=1 for 3 cycles while FU4 keeps fu_out_valid → fu_ready[4]=0 for those cycles and the register is unchanged. Releasing the stall plus a new result → the new packet appears next cycle with no empty cycle.
- Branch result on FU6 with if_take_branch=1, target_pc=0x1000 → fu_c_in[2].target_pc=0x1000 and rob_entry preserved.
- Squash while FUs 1 and 6 are held and FU2 is capturing → fu_finish=0 next cycle and FU2's capture is dropped.
- Async reset pulse mid-cycle with FUs held → outputs go to zero before the next clock edge. With FU_CBUF_PERF_EN, 5 stall cycles on FU0 → stall_cycles=5 and max_hold=5.
